nvme_ucq_wr: RTL and testbench

- Write-side ingest for the microcontroller completion queue.
- Accepts posted-write beats of 16B CQ entries from the PCIe receive path.
- Range-checks and decodes the target address, generates per-byte odd parity, and drives the CQ memory write port (cq_wren/cq_wraddr/cq_wrdata) of the CQ stage.
- Tracks the expected write tail and wrap phase; flags protocol errors to the microcontroller status logic.

---
 rtl/nvme_ucq_pkg.sv | 21 ++
 rtl/nvme_pgen.sv | 25 ++
 rtl/nvme_ucq_wr_dec.sv | 34 +++
 rtl/nvme_ucq_wr.sv | 205 ++++++++++++++++++++
 tb/tb_nvme_ucq_wr.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nvme_ucq_pkg.sv
// ============================================================================
// Module  : nvme_ucq_pkg
// Purpose : Shared types and constants for the microcontroller CQ write path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package nvme_ucq_pkg;

    localparam int CQ_ENTRY_BYTES = 16;
    localparam int CQ_PHASE_BIT   = 112;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_DROP = 2'd2
    } ucq_wr_state_e;

endpackage

`default_nettype wire

// File: rtl/nvme_pgen.sv
// ============================================================================
// Module  : nvme_pgen
// Purpose : Odd parity generator, one parity bit per BITS_PER_PARITY_BIT bits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nvme_pgen #(
    parameter int BITS_PER_PARITY_BIT = 8,
    parameter int WIDTH               = 128
) (
    input  logic [WIDTH-1:0]                     data_i,
    output logic [WIDTH/BITS_PER_PARITY_BIT-1:0] parity_o
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH / BITS_PER_PARITY_BIT; gi++) begin : g_par
            assign parity_o[gi] = ~^data_i[gi*BITS_PER_PARITY_BIT +: BITS_PER_PARITY_BIT];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/nvme_ucq_wr_dec.sv
// ============================================================================
// Module  : nvme_ucq_wr_dec
// Purpose : Converts a TLP byte address into a CQ entry index and range flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nvme_ucq_wr_dec #(
    parameter int NUM_ENTRIES  = 4,
    parameter int CQ_PTR_WIDTH = $clog2(NUM_ENTRIES)
) (
    input  logic [63:0]             base_addr_i,
    input  logic [63:0]             addr_i,
    output logic                    in_range_o,
    output logic [CQ_PTR_WIDTH-1:0] idx_o
);

    import nvme_ucq_pkg::*;

    localparam int c_SHIFT = $clog2(CQ_ENTRY_BYTES);

    logic [63:0]        w_offset;
    logic [63-c_SHIFT:0] w_entry;

    // Modular subtraction: addresses below the base wrap to huge offsets.
    assign w_offset   = addr_i - base_addr_i;
    assign w_entry    = w_offset[63:c_SHIFT];
    assign in_range_o = (w_offset[c_SHIFT-1:0] == '0) &&
                        (w_entry < (64-c_SHIFT)'(NUM_ENTRIES));
    assign idx_o      = w_entry[CQ_PTR_WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/nvme_ucq_wr.sv
// ============================================================================
// Module  : nvme_ucq_wr
// Purpose : CQ write ingest: decode, parity, write port, tail/phase tracking.
//           Optional phase-tag check enabled by NVME_UCQ_WR_PHASE_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nvme_ucq_wr #(
    parameter int NUM_ENTRIES    = 4,
    parameter int CQ_PTR_WIDTH   = $clog2(NUM_ENTRIES),
    parameter int CQ_WRWIDTH     = 128,
    parameter int CQ_PAR_WRWIDTH = 16,
    parameter int CQ_ADDR_WIDTH  = $clog2(NUM_ENTRIES)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 cq_reset,
    input  logic [63:0]                          cq_base_addr,
    input  logic                                 rxq_valid,
    output logic                                 rxq_ready,
    input  logic                                 rxq_sof,
    input  logic                                 rxq_eof,
    input  logic [63:0]                          rxq_addr,
    input  logic [CQ_WRWIDTH-1:0]                rxq_data,
    output logic                                 cq_wren,
    output logic [CQ_ADDR_WIDTH-1:0]             cq_wraddr,
    output logic [CQ_PAR_WRWIDTH+CQ_WRWIDTH-1:0] cq_wrdata,
    output logic [CQ_PTR_WIDTH-1:0]              cq_wr_tail,
    output logic                                 cq_wr_phase,
    output logic                                 cq_wr_range_err,
    output logic                                 cq_wr_seq_err,
    output logic                                 cq_wr_phase_err,
    output logic [15:0]                          cq_wr_err_count
);

    import nvme_ucq_pkg::*;

    localparam logic [CQ_PTR_WIDTH-1:0] c_LAST_IDX = CQ_PTR_WIDTH'(NUM_ENTRIES - 1);
    localparam logic [CQ_PTR_WIDTH-1:0] c_IDX_ONE  = CQ_PTR_WIDTH'(1);

    ucq_wr_state_e                        state_q, state_d;
    logic [CQ_PTR_WIDTH-1:0]              idx_q, idx_d;
    logic [CQ_PTR_WIDTH-1:0]              tail_q, tail_d;
    logic                                 phase_q, phase_d;
    logic                                 wren_q;
    logic [CQ_ADDR_WIDTH-1:0]             wraddr_q;
    logic [CQ_PAR_WRWIDTH+CQ_WRWIDTH-1:0] wrdata_q;
    logic                                 range_err_q, range_err_d;
    logic                                 seq_err_q;
    logic [15:0]                          err_cnt_q, err_cnt_d;

    logic                      w_accept;
    logic                      w_wr;
    logic [CQ_PTR_WIDTH-1:0]   w_wr_idx;
    logic                      w_dec_in_range;
    logic [CQ_PTR_WIDTH-1:0]   w_dec_idx;
    logic [CQ_PAR_WRWIDTH-1:0] w_parity;
    logic                      w_seq_err;
    logic [1:0]                w_err_inc;
    logic [16:0]               w_cnt_sum;

    assign rxq_ready = !(reset || cq_reset);
    assign w_accept  = rxq_valid && rxq_ready;

    nvme_ucq_wr_dec #(
        .NUM_ENTRIES  (NUM_ENTRIES),
        .CQ_PTR_WIDTH (CQ_PTR_WIDTH)
    ) u_dec (
        .base_addr_i (cq_base_addr),
        .addr_i      (rxq_addr),
        .in_range_o  (w_dec_in_range),
        .idx_o       (w_dec_idx)
    );

    nvme_pgen #(
        .BITS_PER_PARITY_BIT (8),
        .WIDTH               (CQ_WRWIDTH)
    ) u_pgen (
        .data_i   (rxq_data),
        .parity_o (w_parity)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        w_wr        = 1'b0;
        w_wr_idx    = idx_q;
        range_err_d = 1'b0;
        if (w_accept) begin
            if (rxq_sof) begin
                // A sof inside an open TLP restarts decoding but is still flagged.
                range_err_d = (state_q != ST_IDLE) || !w_dec_in_range;
                if (w_dec_in_range) begin
                    w_wr     = 1'b1;
                    w_wr_idx = w_dec_idx;
                    idx_d    = w_dec_idx;
                    state_d  = rxq_eof ? ST_IDLE : ST_DATA;
                end else begin
                    state_d  = rxq_eof ? ST_IDLE : ST_DROP;
                end
            end else begin
                case (state_q)
                    ST_DATA: begin
                        if (idx_q == c_LAST_IDX) begin
                            range_err_d = 1'b1;
                            state_d     = rxq_eof ? ST_IDLE : ST_DROP;
                        end else begin
                            w_wr     = 1'b1;
                            w_wr_idx = idx_q + c_IDX_ONE;
                            idx_d    = w_wr_idx;
                            state_d  = rxq_eof ? ST_IDLE : ST_DATA;
                        end
                    end
                    default: state_d = rxq_eof ? ST_IDLE : ST_DROP;
                endcase
            end
        end
    end

    always_comb begin
        tail_d    = tail_q;
        phase_d   = phase_q;
        w_seq_err = 1'b0;
        if (w_wr) begin
            w_seq_err = (w_wr_idx != tail_q);
            tail_d    = w_wr_idx + c_IDX_ONE;
            if (w_wr_idx == c_LAST_IDX) begin
                phase_d = !phase_q;
            end
        end
    end

`ifdef NVME_UCQ_WR_PHASE_CHECK_EN
    logic w_phase_err;
    logic phase_err_q;

    assign w_phase_err     = w_wr && (rxq_data[CQ_PHASE_BIT] != phase_q);
    assign w_err_inc       = 2'(range_err_d) + 2'(w_seq_err) + 2'(w_phase_err);
    assign cq_wr_phase_err = phase_err_q;

    always_ff @(posedge clk) begin
        if (reset || cq_reset) begin
            phase_err_q <= 1'b0;
        end else begin
            phase_err_q <= w_phase_err;
        end
    end
`else
    assign w_err_inc       = 2'(range_err_d) + 2'(w_seq_err);
    assign cq_wr_phase_err = 1'b0;
`endif

    assign w_cnt_sum = {1'b0, err_cnt_q} + {15'd0, w_err_inc};
    assign err_cnt_d = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            tail_q      <= '0;
            phase_q     <= 1'b1;
            wren_q      <= 1'b0;
            wraddr_q    <= '0;
            wrdata_q    <= '0;
            range_err_q <= 1'b0;
            seq_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else if (cq_reset) begin
            // Queue-level reset keeps the error history.
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            tail_q      <= '0;
            phase_q     <= 1'b1;
            wren_q      <= 1'b0;
            range_err_q <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tail_q      <= tail_d;
            phase_q     <= phase_d;
            wren_q      <= w_wr;
            range_err_q <= range_err_d;
            seq_err_q   <= w_seq_err;
            err_cnt_q   <= err_cnt_d;
            if (w_wr) begin
                wraddr_q <= CQ_ADDR_WIDTH'(w_wr_idx);
                wrdata_q <= {w_parity, rxq_data};
            end
        end
    end

    assign cq_wren         = wren_q;
    assign cq_wraddr       = wraddr_q;
    assign cq_wrdata       = wrdata_q;
    assign cq_wr_tail      = tail_q;
    assign cq_wr_phase     = phase_q;
    assign cq_wr_range_err = range_err_q;
    assign cq_wr_seq_err   = seq_err_q;
    assign cq_wr_err_count = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_nvme_ucq_wr.sv
// ============================================================================
// Module  : tb_nvme_ucq_wr
// Purpose : Self-checking bench for nvme_ucq_wr (NUM_ENTRIES=4); honours
//           NVME_UCQ_WR_PHASE_CHECK_EN in its reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nvme_ucq_wr;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset, cq_reset;
    logic [63:0]  cq_base_addr;
    logic         rxq_valid, rxq_ready, rxq_sof, rxq_eof;
    logic [63:0]  rxq_addr;
    logic [127:0] rxq_data;
    logic         cq_wren;
    logic [1:0]   cq_wraddr;
    logic [143:0] cq_wrdata;
    logic [1:0]   cq_wr_tail;
    logic         cq_wr_phase, cq_wr_range_err, cq_wr_seq_err, cq_wr_phase_err;
    logic [15:0]  cq_wr_err_count;

    nvme_ucq_wr #(.NUM_ENTRIES(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .cq_reset        (cq_reset),
        .cq_base_addr    (cq_base_addr),
        .rxq_valid       (rxq_valid),
        .rxq_ready       (rxq_ready),
        .rxq_sof         (rxq_sof),
        .rxq_eof         (rxq_eof),
        .rxq_addr        (rxq_addr),
        .rxq_data        (rxq_data),
        .cq_wren         (cq_wren),
        .cq_wraddr       (cq_wraddr),
        .cq_wrdata       (cq_wrdata),
        .cq_wr_tail      (cq_wr_tail),
        .cq_wr_phase     (cq_wr_phase),
        .cq_wr_range_err (cq_wr_range_err),
        .cq_wr_seq_err   (cq_wr_seq_err),
        .cq_wr_phase_err (cq_wr_phase_err),
        .cq_wr_err_count (cq_wr_err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: queue pointers plus TLP-level progress.
    int          m_tail;
    bit          m_phase;
    int          m_cnt;
    bit          m_open;
    bit          m_live;
    logic [63:0] m_off;
    int          m_k;

    int o_wr, o_seq, o_rng;

    typedef struct {
        logic [63:0] off;
        int          nb;
        int          wr;
        int          seq;
        int          rng;
        int          tail;
        bit          ph;
    } vec_t;

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] odd_par(input logic [127:0] d);
        logic [15:0] p;
        for (int i = 0; i < 16; i++) p[i] = ($countones(d[8*i +: 8]) % 2) == 0;
        return p;
    endfunction

    task automatic model_reset();
        m_tail = 0; m_phase = 1'b1; m_cnt = 0; m_open = 1'b0; m_live = 1'b0; m_k = 0; m_off = '0;
    endtask

    task automatic model_cq_reset();
        m_tail = 0; m_phase = 1'b1; m_open = 1'b0; m_live = 1'b0;
    endtask

    task automatic model_beat(input bit sof, input bit eof, input logic [63:0] addr,
                              input logic [127:0] data, output bit e_wr, output int e_idx,
                              output bit e_rng, output bit e_seq, output bit e_perr);
        bit          ok0;
        logic [63:0] idx;
        e_wr = 0; e_idx = 0; e_rng = 0; e_seq = 0; e_perr = 0;
        if (sof) begin
            e_rng  = m_open;
            m_off  = addr - cq_base_addr;
            m_k    = 0;
            m_live = 1'b1;
        end else if (m_open && m_live) begin
            m_k++;
        end else begin
            m_live = 1'b0;
        end
        if (m_live) begin
            ok0 = (m_off % 16 == 0) && (m_off / 16 < N);
            idx = m_off / 16 + 64'(m_k);
            if (!ok0) begin
                if (sof) e_rng = 1'b1;
            end else if (idx < N) begin
                e_wr  = 1'b1;
                e_idx = int'(idx);
            end else if (idx == N) begin
                e_rng = 1'b1;
            end
        end
        if (e_wr) begin
            e_seq = (e_idx != m_tail);
`ifdef NVME_UCQ_WR_PHASE_CHECK_EN
            e_perr = (data[112] != m_phase);
`endif
            m_tail = (e_idx + 1) % N;
            if (e_idx == N - 1) m_phase = !m_phase;
        end
        m_cnt = m_cnt + int'(e_rng) + int'(e_seq) + int'(e_perr);
        if (m_cnt > 65535) m_cnt = 65535;
        m_open = !eof;
    endtask

    task automatic check_outs(input bit ew, input int ei, input logic [127:0] d,
                              input bit er, input bit es, input bit ep);
        chk("wren", cq_wren, ew);
        if (ew) begin
            chk("wraddr", cq_wraddr, 144'(ei));
            chk("wrdata", cq_wrdata, {odd_par(d), d});
        end
        chk("range_err", cq_wr_range_err, er);
        chk("seq_err", cq_wr_seq_err, es);
        chk("phase_err", cq_wr_phase_err, ep);
        chk("tail", cq_wr_tail, 144'(m_tail));
        chk("phase", cq_wr_phase, m_phase);
        chk("err_count", cq_wr_err_count, 144'(m_cnt));
        o_wr  += int'(cq_wren);
        o_seq += int'(cq_wr_seq_err);
        o_rng += int'(cq_wr_range_err);
    endtask

    task automatic beat(input bit sof, input bit eof, input logic [63:0] addr, input logic [127:0] data);
        bit ew, er, es, ep;
        int ei;
        rxq_valid = 1'b1; rxq_sof = sof; rxq_eof = eof; rxq_addr = addr; rxq_data = data;
        #1;
        chk("ready", rxq_ready, 1'b1);
        @(posedge clk);
        #1;
        model_beat(sof, eof, addr, data, ew, ei, er, es, ep);
        rxq_valid = 1'b0; rxq_sof = 1'b0; rxq_eof = 1'b0;
        check_outs(ew, ei, data, er, es, ep);
    endtask

    task automatic idle();
        rxq_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outs(0, 0, '0, 0, 0, 0);
    endtask

    task automatic pulse_cq_reset();
        rxq_valid = 1'($urandom_range(0, 1));
        rxq_sof   = 1'($urandom_range(0, 1));
        cq_reset  = 1'b1;
        #1;
        chk("ready_cq_reset", rxq_ready, 1'b0);
        @(posedge clk);
        #1;
        cq_reset  = 1'b0;
        rxq_valid = 1'b0;
        rxq_sof   = 1'b0;
        model_cq_reset();
        check_outs(0, 0, '0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; rxq_valid = 1'b0;
        #1;
        chk("ready_in_reset", rxq_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk("rst_wraddr", cq_wraddr, '0);
        chk("rst_wrdata", cq_wrdata, '0);
        check_outs(0, 0, '0, 0, 0, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[9];
        logic [127:0] d_inc, d;
        logic [63:0]  off;
        int           nb, sel, c0;

        vecs[0] = '{64'h20, 1, 1, 1, 0, 3, 1'b1};
        vecs[1] = '{64'h00, 4, 4, 1, 0, 0, 1'b0};
        vecs[2] = '{64'h30, 2, 1, 1, 1, 0, 1'b1};
        vecs[3] = '{64'h08, 1, 0, 0, 1, 0, 1'b1};
        vecs[4] = '{64'h40, 1, 0, 0, 1, 0, 1'b1};
        vecs[5] = '{64'h10, 3, 3, 1, 0, 0, 1'b0};
        vecs[6] = '{64'h00, 2, 2, 0, 0, 2, 1'b0};
        vecs[7] = '{-64'sd16, 1, 0, 0, 1, 2, 1'b0};
        vecs[8] = '{64'h30, 1, 1, 1, 0, 0, 1'b1};

        for (int i = 0; i < 16; i++) d_inc[8*i +: 8] = 8'(i);

        cq_reset = 1'b0; rxq_valid = 1'b0; rxq_sof = 1'b0; rxq_eof = 1'b0;
        rxq_addr = '0; rxq_data = '0;
        cq_base_addr = 64'h0000_00AB_CDEF_1200;
        do_reset();

        // Directed TLP table
        for (int v = 0; v < 9; v++) begin
            o_wr = 0; o_seq = 0; o_rng = 0;
            for (int b = 0; b < vecs[v].nb; b++)
                beat(b == 0, b == vecs[v].nb - 1,
                     (b == 0) ? cq_base_addr + vecs[v].off : {$urandom, $urandom}, d_inc);
            chk("tbl_writes", 144'(o_wr), 144'(vecs[v].wr));
            chk("tbl_seq", 144'(o_seq), 144'(vecs[v].seq));
            chk("tbl_range", 144'(o_rng), 144'(vecs[v].rng));
            chk("tbl_tail", cq_wr_tail, 144'(vecs[v].tail));
            chk("tbl_phase", cq_wr_phase, vecs[v].ph);
            idle();
        end

        // sof inside an open TLP: range and seq pulse together, count +2
        d = d_inc;
        d[112] = 1'b1;
        c0 = int'(cq_wr_err_count);
        beat(1, 0, cq_base_addr + 64'h00, d);
        beat(1, 1, cq_base_addr + 64'h20, d);
        chk("both_pulse", {cq_wr_range_err, cq_wr_seq_err}, 2'b11);
        chk("both_count", cq_wr_err_count, 144'(c0 + 2));
        idle();

        // cq_reset mid-TLP: remaining beats are dropped, count kept
        beat(1, 0, cq_base_addr, d);
        c0 = int'(cq_wr_err_count);
        pulse_cq_reset();
        for (int b = 1; b < 4; b++) beat(0, b == 3, {$urandom, $urandom}, d);
        chk("cqr_tail", cq_wr_tail, 2'd0);
        chk("cqr_phase", cq_wr_phase, 1'b1);
        chk("cqr_count", cq_wr_err_count, 144'(c0));
        beat(1, 1, cq_base_addr, d);
        chk("cqr_after_wren", cq_wren, 1'b1);
        chk("cqr_after_seq", cq_wr_seq_err, 1'b0);
        idle();

        // Randomized TLP traffic against the model
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) cq_base_addr = {$urandom, $urandom} & ~64'hF;
            sel = $urandom_range(0, 5);
            if (sel <= 3)      off = 64'($urandom_range(0, N + 1)) * 64'd16;
            else if (sel == 4) off = 64'($urandom_range(1, 15)) + 64'd16 * 64'($urandom_range(0, N - 1));
            else               off = {$urandom, $urandom};
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0) idle();
                if ($urandom_range(0, 49) == 0) pulse_cq_reset();
                d = {$urandom, $urandom, $urandom, $urandom};
                if (b > 0 && $urandom_range(0, 29) == 0)
                    beat(1, b == nb - 1, cq_base_addr + 64'(16 * $urandom_range(0, N)), d);
                else
                    beat(b == 0, b == nb - 1, (b == 0) ? cq_base_addr + off : {$urandom, $urandom}, d);
            end
        end
        idle();

        // Error counter saturation via repeated in-TLP sof beats
        beat(1, 0, cq_base_addr + 64'h20, d_inc);
        for (int s = 0; s < 40000 && m_cnt < 65535; s++) begin
            d = d_inc;
            d[112] = m_phase;
            beat(1, 0, cq_base_addr + 64'h20, d);
        end
        beat(1, 0, cq_base_addr + 64'h20, d_inc);
        chk("count_saturated", cq_wr_err_count, 16'hFFFF);
        beat(0, 1, cq_base_addr, d_inc);

        do_reset();
        chk("count_after_reset", cq_wr_err_count, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
